hazard_md_ctrl: RTL and testbench

- Pipeline hazard and multiply/divide scheduling controller for the 5-stage CPU.
- Compares D-stage register sources (A1/A2 with Tuse) against E/M-stage destinations (A3 with Tnew). Sequences the iterative mult/div unit through a busy counter.
- Drives StallD, which holds PC and the D register, and FlushE, which inserts a bubble into the E pipeline register.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_md_ctrl_if.sv | 38 +++
 rtl/hazard_md_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_md_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_md_ctrl_if.sv
// Pipeline-side bundle for the hazard / mult-div controller.
// The slave side is the controller. The master side is the pipeline that
// feeds it the D/E/M register fields and the E-stage mult/div launch.
interface hazard_md_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       A1D;
   logic [4:0]       A2D;
   logic [2:0]       Tuse1D;
   logic [2:0]       Tuse2D;
   logic             isMdD;
   logic [4:0]       A3E;
   logic [2:0]       TnewE;
   logic [4:0]       A3M;
   logic [2:0]       TnewM;
   logic             md_start;
   logic             md_op;
   logic             StallD;
   logic             FlushE;
   logic             md_busy;
   logic             md_done;
   logic             md_err;
   logic [CNT_W-1:0] stall_cnt;

   modport slave (
      input  A1D, A2D, Tuse1D, Tuse2D, isMdD,
      input  A3E, TnewE, A3M, TnewM,
      input  md_start, md_op,
      output StallD, FlushE, md_busy, md_done, md_err, stall_cnt
   );

   modport master (
      output A1D, A2D, Tuse1D, Tuse2D, isMdD,
      output A3E, TnewE, A3M, TnewM,
      output md_start, md_op,
      input  StallD, FlushE, md_busy, md_done, md_err, stall_cnt
   );
endinterface

// File: rtl/hazard_md_ctrl.sv
// Hazard detection and mult/div scheduling for the 5-stage pipeline.
// A D-stage source stalls when an E/M producer will not have its result
// ready before the source is needed (Tuse < Tnew). Mult/div instructions
// also stall in D while the iterative unit is busy or being launched.
// A saturating counter records how many cycles the pipeline spent stalled.
module hazard_md_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   hazard_md_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter is loaded with LAT-1 so that BUSY lasts exactly LAT cycles.
   localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT - 1);

   state_t           state_q;
   state_t           state_d;
   logic [3:0]       count_q;
   logic [3:0]       count_d;
   logic             err_q;
   logic             err_d;
   logic [CNT_W-1:0] stall_cnt_q;

   logic             hazard_rs;
   logic             hazard_rt;
   logic             hazard_md;
   logic             stall;
   logic             busy;

   assign busy = (state_q == BUSY);

   // Data and mult/div hazards; $0, unused sources and Tnew==0 never stall.
   always_comb begin
      hazard_rs = (bus.A1D != 5'd0) && (bus.Tuse1D != 3'd7) &&
                  (((bus.A1D == bus.A3E) && (bus.Tuse1D < bus.TnewE)) ||
                   ((bus.A1D == bus.A3M) && (bus.Tuse1D < bus.TnewM)));
      hazard_rt = (bus.A2D != 5'd0) && (bus.Tuse2D != 3'd7) &&
                  (((bus.A2D == bus.A3E) && (bus.Tuse2D < bus.TnewE)) ||
                   ((bus.A2D == bus.A3M) && (bus.Tuse2D < bus.TnewM)));
      hazard_md = bus.isMdD && (busy || bus.md_start);
      stall     = hazard_rs || hazard_rt || hazard_md;
   end

   // Mult/div sequencing: a launch during BUSY is dropped and flagged sticky.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.md_start) begin
               state_d = BUSY;
               count_d = bus.md_op ? DIV_LOAD : MULT_LOAD;
            end
         end
         BUSY: begin
            if (bus.md_start) begin
               err_d = 1'b1;
            end
            if (count_q == 4'd0) begin
               state_d = DONE;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         DONE: begin
            if (bus.md_start) begin
               state_d = BUSY;
               count_d = bus.md_op ? DIV_LOAD : MULT_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, busy counter and sticky error register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Stall-cycle performance counter, pinned at all-ones once it gets there.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.StallD    = stall;
   assign bus.FlushE    = stall;
   assign bus.md_busy   = busy;
   assign bus.md_done   = (state_q == DONE);
   assign bus.md_err    = err_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Self-checking bench for hazard_md_ctrl.
// A 32-bit counter instance carries the main tests; a 4-bit counter instance
// shares the same stimulus so its saturation at 15 can be observed.
module tb_hazard_md_ctrl;

   typedef struct {
      logic [4:0] a1;
      logic [2:0] t1;
      logic [4:0] a2;
      logic [2:0] t2;
      logic       ismd;
      logic [4:0] a3e;
      logic [2:0] te;
      logic [4:0] a3m;
      logic [2:0] tm;
      logic       start;
      logic       op;
   } in_t;

   typedef struct {
      logic stall;
      logic busy;
      logic done;
      logic err;
   } exp_t;

   typedef struct {
      in_t  vin;
      logic stall;
   } vec_t;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   int   modelCnt;
   exp_t expQ[$];
   vec_t vecs[14];

   hazard_md_ctrl_if #(.CNT_W(32)) bus ();
   hazard_md_ctrl_if #(.CNT_W(4))  busS ();

   hazard_md_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   hazard_md_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dutS (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busS)
   );

   assign busS.A1D      = bus.A1D;
   assign busS.A2D      = bus.A2D;
   assign busS.Tuse1D   = bus.Tuse1D;
   assign busS.Tuse2D   = bus.Tuse2D;
   assign busS.isMdD    = bus.isMdD;
   assign busS.A3E      = bus.A3E;
   assign busS.TnewE    = bus.TnewE;
   assign busS.A3M      = bus.A3M;
   assign busS.TnewM    = bus.TnewM;
   assign busS.md_start = bus.md_start;
   assign busS.md_op    = bus.md_op;

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   function automatic in_t mk(input logic [4:0] a1, input logic [2:0] t1,
                              input logic [4:0] a2, input logic [2:0] t2,
                              input logic ismd,
                              input logic [4:0] a3e, input logic [2:0] te,
                              input logic [4:0] a3m, input logic [2:0] tm);
      in_t v;
      v.a1 = a1; v.t1 = t1; v.a2 = a2; v.t2 = t2; v.ismd = ismd;
      v.a3e = a3e; v.te = te; v.a3m = a3m; v.tm = tm;
      v.start = 1'b0; v.op = 1'b0;
      return v;
   endfunction

   function automatic in_t quiet();
      return mk(5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 5'd0, 3'd0, 5'd0, 3'd0);
   endfunction

   function automatic exp_t ex(input logic s, input logic b, input logic d, input logic e);
      exp_t r;
      r.stall = s; r.busy = b; r.done = d; r.err = e;
      return r;
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic drive(input in_t v);
      bus.A1D      = v.a1;
      bus.Tuse1D   = v.t1;
      bus.A2D      = v.a2;
      bus.Tuse2D   = v.t2;
      bus.isMdD    = v.ismd;
      bus.A3E      = v.a3e;
      bus.TnewE    = v.te;
      bus.A3M      = v.a3m;
      bus.TnewM    = v.tm;
      bus.md_start = v.start;
      bus.md_op    = v.op;
   endtask

   task automatic applyStimulus(input in_t v, input exp_t e);
      @(negedge clk);
      drive(v);
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      int   satCnt;
      #2;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s scoreboard empty", tag);
      end else begin
         e = expQ.pop_front();
         satCnt = (modelCnt > 15) ? 15 : modelCnt;
         cmp({tag, " StallD"},  {31'd0, bus.StallD},  {31'd0, e.stall});
         cmp({tag, " FlushE"},  {31'd0, bus.FlushE},  {31'd0, e.stall});
         cmp({tag, " md_busy"}, {31'd0, bus.md_busy}, {31'd0, e.busy});
         cmp({tag, " md_done"}, {31'd0, bus.md_done}, {31'd0, e.done});
         cmp({tag, " md_err"},  {31'd0, bus.md_err},  {31'd0, e.err});
         cmp({tag, " stall_cnt"}, bus.stall_cnt, 32'(modelCnt));
         cmp({tag, " stall_cnt4"}, {28'd0, busS.stall_cnt}, 32'(satCnt));
         if (e.stall) modelCnt++;
      end
   endtask

   task automatic cycle(input string tag, input in_t v, input exp_t e);
      applyStimulus(v, e);
      checkOutput(tag);
   endtask

   initial begin
      in_t v;
      checks   = 0;
      errors   = 0;
      modelCnt = 0;

      vecs[0]  = '{mk(5'd3, 3'd0, 5'd0, 3'd7, 1'b0, 5'd3, 3'd1, 5'd0, 3'd0), 1'b1};
      vecs[1]  = '{mk(5'd3, 3'd0, 5'd0, 3'd7, 1'b0, 5'd0, 3'd1, 5'd0, 3'd0), 1'b0};
      vecs[2]  = '{mk(5'd0, 3'd0, 5'd0, 3'd7, 1'b0, 5'd0, 3'd1, 5'd0, 3'd0), 1'b0};
      vecs[3]  = '{mk(5'd0, 3'd7, 5'd5, 3'd1, 1'b0, 5'd0, 3'd0, 5'd5, 3'd1), 1'b0};
      vecs[4]  = '{mk(5'd0, 3'd7, 5'd5, 3'd1, 1'b0, 5'd0, 3'd0, 5'd5, 3'd2), 1'b1};
      vecs[5]  = '{mk(5'd0, 3'd7, 5'd5, 3'd1, 1'b0, 5'd0, 3'd0, 5'd5, 3'd2), 1'b1};
      vecs[6]  = '{mk(5'd7, 3'd7, 5'd0, 3'd7, 1'b0, 5'd7, 3'd3, 5'd0, 3'd0), 1'b0};
      vecs[7]  = '{mk(5'd7, 3'd2, 5'd0, 3'd7, 1'b0, 5'd7, 3'd0, 5'd0, 3'd0), 1'b0};
      vecs[8]  = '{mk(5'd9, 3'd1, 5'd0, 3'd7, 1'b0, 5'd0, 3'd0, 5'd9, 3'd2), 1'b1};
      vecs[9]  = '{mk(5'd8, 3'd0, 5'd4, 3'd0, 1'b0, 5'd4, 3'd1, 5'd0, 3'd0), 1'b1};
      vecs[10] = '{mk(5'd6, 3'd2, 5'd0, 3'd7, 1'b0, 5'd6, 3'd2, 5'd0, 3'd0), 1'b0};
      vecs[11] = '{mk(5'd6, 3'd1, 5'd0, 3'd7, 1'b0, 5'd6, 3'd2, 5'd6, 3'd0), 1'b1};
      vecs[12] = '{mk(5'd0, 3'd7, 5'd0, 3'd7, 1'b1, 5'd0, 3'd0, 5'd0, 3'd0), 1'b0};
      vecs[13] = '{mk(5'd0, 3'd7, 5'd0, 3'd0, 1'b0, 5'd0, 3'd3, 5'd0, 3'd3), 1'b0};

      // Reset with quiet inputs; outputs must be at their reset values.
      reset_n = 1'b0;
      drive(quiet());
      @(posedge clk);
      @(negedge clk);
      cmp("reset md_busy", {31'd0, bus.md_busy}, 32'd0);
      cmp("reset md_done", {31'd0, bus.md_done}, 32'd0);
      cmp("reset md_err", {31'd0, bus.md_err}, 32'd0);
      cmp("reset stall_cnt", bus.stall_cnt, 32'd0);
      cmp("reset StallD", {31'd0, bus.StallD}, 32'd0);
      reset_n = 1'b1;

      // Data hazard table.
      for (int i = 0; i < 14; i++) begin
         cycle($sformatf("vec%0d", i), vecs[i].vin, ex(vecs[i].stall, 1'b0, 1'b0, 1'b0));
      end

      // Mult: launch with a D-stage mult/div behind it, 5 busy cycles, done.
      v = quiet(); v.start = 1'b1; v.op = 1'b0; v.ismd = 1'b1;
      cycle("mult start", v, ex(1'b1, 1'b0, 1'b0, 1'b0));
      v = quiet(); v.ismd = 1'b1;
      cycle("mult busy1", v, ex(1'b1, 1'b1, 1'b0, 1'b0));
      for (int i = 2; i <= 5; i++) begin
         cycle($sformatf("mult busy%0d", i), quiet(), ex(1'b0, 1'b1, 1'b0, 1'b0));
      end
      cycle("mult done", quiet(), ex(1'b0, 1'b0, 1'b1, 1'b0));
      cycle("mult idle", quiet(), ex(1'b0, 1'b0, 1'b0, 1'b0));

      // Div: 10 busy cycles; a second launch on busy cycle 4 only raises md_err.
      v = quiet(); v.start = 1'b1; v.op = 1'b1;
      cycle("div start", v, ex(1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 1; i <= 10; i++) begin
         v = quiet();
         if (i == 4) begin
            v.start = 1'b1; v.op = 1'b0;
         end
         cycle($sformatf("div busy%0d", i), v, ex(1'b0, 1'b1, 1'b0, (i >= 5)));
      end
      cycle("div done", quiet(), ex(1'b0, 1'b0, 1'b1, 1'b1));
      cycle("div idle", quiet(), ex(1'b0, 1'b0, 1'b0, 1'b1));

      // Back-to-back: relaunch during DONE, then async reset on busy cycle 3.
      v = quiet(); v.start = 1'b1;
      cycle("b2b start", v, ex(1'b0, 1'b0, 1'b0, 1'b1));
      for (int i = 1; i <= 5; i++) begin
         cycle($sformatf("b2b busy%0d", i), quiet(), ex(1'b0, 1'b1, 1'b0, 1'b1));
      end
      v = quiet(); v.start = 1'b1;
      cycle("b2b done", v, ex(1'b0, 1'b0, 1'b1, 1'b1));
      for (int i = 1; i <= 3; i++) begin
         cycle($sformatf("b2b rebusy%0d", i), quiet(), ex(1'b0, 1'b1, 1'b0, 1'b1));
      end
      #1;
      reset_n = 1'b0;
      #1;
      cmp("async md_busy", {31'd0, bus.md_busy}, 32'd0);
      cmp("async md_done", {31'd0, bus.md_done}, 32'd0);
      cmp("async md_err", {31'd0, bus.md_err}, 32'd0);
      cmp("async stall_cnt", bus.stall_cnt, 32'd0);
      cmp("async stall_cnt4", {28'd0, busS.stall_cnt}, 32'd0);
      modelCnt = 0;
      @(negedge clk);
      reset_n = 1'b1;
      cycle("post reset", quiet(), ex(1'b0, 1'b0, 1'b0, 1'b0));

      // Hold a data hazard for 20 cycles; the 4-bit counter pins at 15.
      v = mk(5'd1, 3'd0, 5'd0, 3'd7, 1'b0, 5'd1, 3'd1, 5'd0, 3'd0);
      for (int i = 0; i < 20; i++) begin
         cycle($sformatf("sat%0d", i), v, ex(1'b1, 1'b0, 1'b0, 1'b0));
      end
      cycle("sat end", quiet(), ex(1'b0, 1'b0, 1'b0, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
